record_play_ctrl: RTL

Parametrised record/playback controller for the practice board's switch panel. Debounces active-low record and play switches, runs a record/play state machine with a sample-rate address pointer, and keeps a stored length for each of several channels. It sits between the switch inputs and a single-port sample memory, driving write/read strobes, address and channel, plus status indicators.

---
 rtl/record_play_pkg.sv | 17 +
 rtl/switch_debounce.sv | 42 ++++
 rtl/record_play_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/record_play_pkg.sv
// Shared types and helpers for the record/playback controller.
package record_play_pkg;

   typedef enum logic [1:0] {IDLE, RECORD, PLAY, HOLD} state_t;

   // Smallest debounce count that still rejects a single-sample glitch.
   localparam int DEB_MIN = 2;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic int num_ch_of(input int ch_w);
      return 1 << ch_w;
   endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output level
// follows the raw switch only after DEB_CNT consecutive equal samples.
module switch_debounce
   import record_play_pkg::*;
#(
   parameter int DEB_CNT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int CNT_LIM = (DEB_CNT < DEB_MIN) ? DEB_MIN : DEB_CNT;
   localparam int CNT_W   = $clog2(CNT_LIM);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   // Released switches read high, so every stage resets to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(CNT_LIM - 1)) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/record_play_ctrl.sv
// Record/playback controller: debounced switches, state machine, sample pointer
// and per-channel lengths. Define RECORD_PLAY_LOOP_EN for looping playback.
module record_play_ctrl
   import record_play_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int CH_W    = 2,
   parameter int DEB_CNT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              record_switch,
   input  logic              play_switch,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic              sample_tick,
   output logic              record_output,
   output logic              play_output,
   output logic              mem_we,
   output logic              mem_re,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [CH_W-1:0]   mem_ch,
   output logic              busy
);

   localparam int DEPTH  = depth_of(ADDR_W);
   localparam int NUM_CH = num_ch_of(CH_W);
   localparam int LEN_W  = ADDR_W + 1;

   logic rec_level;
   logic play_level;
   logic rec_on;
   logic play_on;

   switch_debounce #(.DEB_CNT(DEB_CNT)) u_rec_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (record_switch),
      .level (rec_level)
   );

   switch_debounce #(.DEB_CNT(DEB_CNT)) u_play_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (play_switch),
      .level (play_level)
   );

   assign rec_on  = ~rec_level;
   assign play_on = ~play_level;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [CH_W-1:0]   ch;
   logic [CH_W-1:0]   ch_nxt;
   logic [LEN_W-1:0]  len [NUM_CH];
   logic              len_we;
   logic [LEN_W-1:0]  len_val;
   logic [LEN_W-1:0]  count_after;

   // Number of accesses completed once the current one retires.
   assign count_after = LEN_W'(ptr) + LEN_W'(1);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_nxt = state;
      ptr_nxt   = ptr;
      ch_nxt    = ch;
      len_we    = 1'b0;
      len_val   = '0;
      case (state)
         IDLE: begin
            if (rec_on) begin
               state_nxt = RECORD;
               ch_nxt    = ch_sel;
               ptr_nxt   = '0;
            end else if (play_on && (len[ch_sel] != '0)) begin
               state_nxt = PLAY;
               ch_nxt    = ch_sel;
               ptr_nxt   = '0;
            end
         end
         RECORD: begin
            if (sample_tick && (ptr == ADDR_W'(DEPTH - 1))) begin
               len_we    = 1'b1;
               len_val   = LEN_W'(DEPTH);
               state_nxt = HOLD;
            end else if (sample_tick) begin
               ptr_nxt = ptr + 1'b1;
               if (!rec_on) begin
                  len_we    = 1'b1;
                  len_val   = count_after;
                  state_nxt = IDLE;
               end
            end else if (!rec_on) begin
               len_we    = 1'b1;
               len_val   = LEN_W'(ptr);
               state_nxt = IDLE;
            end
         end
         PLAY: begin
            if (sample_tick && (count_after == len[ch])) begin
`ifdef RECORD_PLAY_LOOP_EN
               ptr_nxt = '0;
               if (!play_on) state_nxt = IDLE;
`else
               state_nxt = HOLD;
`endif
            end else if (sample_tick) begin
               ptr_nxt = ptr + 1'b1;
               if (!play_on) state_nxt = IDLE;
            end else if (!play_on) begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (!rec_on && !play_on) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= '0;
         ch    <= '0;
         // NOTE: the length file is reset because a never-recorded channel must read as empty.
         for (int i = 0; i < NUM_CH; i++) len[i] <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         ch    <= ch_nxt;
         if (len_we) len[ch] <= len_val;
      end
   end

   assign record_output = (state == RECORD);
   assign play_output   = (state == PLAY);
   assign mem_we        = (state == RECORD) && sample_tick;
   assign mem_re        = (state == PLAY) && sample_tick;
   assign mem_addr      = ptr;
   assign mem_ch        = ch;
   assign busy          = (state != IDLE);

endmodule
